// File: rtl/dual_mem_accum_ctrl.sv
// ---------------------------------------------------------------------------
// dual_mem_accum_ctrl
//   Sequencer for the dual block-RAM sum datapath. A start request issues a
//   contiguous, wrapping run of read addresses on the address bus shared by
//   RAM A and RAM B. The sequencer tracks the RAM read latency with a valid
//   shift register and accumulates dout_a + dout_b for each returned word.
//   Completion is signalled with a busy/done handshake. A transaction can be
//   aborted; the partial sum is then kept.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   start      in   transaction request, sampled only in IDLE
//   abort      in   cancel in-progress transaction (wins over start)
//   base_addr  in   first address of the run (latched on start)
//   length     in   number of addresses, 0..2**ADDR_W (latched on start)
//   mem_en     out  RAM enable, high on issue cycles only
//   mem_we     out  RAM write enable, constant 0
//   mem_addr   out  shared RAM address
//   dout_a     in   RAM A read data
//   dout_b     in   RAM B read data
//   busy       out  transaction in progress
//   done       out  one-cycle completion pulse; sum is final in that cycle
//   sum        out  accumulated result, held between transactions
//   overflow   out  sticky carry-out of sum for the current transaction
// ---------------------------------------------------------------------------
module dual_mem_accum_ctrl #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 4,
   parameter int SUM_W  = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] dout_a,
   input  logic [DATA_W-1:0] dout_b,
   output logic              busy,
   output logic              done,
   output logic [SUM_W-1:0]  sum,
   output logic              overflow
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W:0]    rem_q, rem_d;     // issues left, including the current one
   logic [ADDR_W-1:0]  addr_d;
   logic               mem_en_d, busy_d, done_d;
   logic [RD_LAT-1:0]  vld_q, vld_d;     // bit RD_LAT-1 marks a data-return cycle
   logic [RD_LAT-1:0]  vld_rest;         // reads still in flight beyond this cycle
   logic               clr_acc, acc_en;
   logic [SUM_W:0]     acc_full;

   assign mem_we   = 1'b0;
   assign vld_rest = vld_q << 1;

   // Returned data is accumulated only in its valid cycle; an abort in that
   // same cycle discards it together with the rest of the pipeline.
   assign acc_en   = vld_q[RD_LAT-1] & ~abort;
   assign acc_full = {1'b0, sum} + (SUM_W+1)'(dout_a) + (SUM_W+1)'(dout_b);

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      addr_d   = mem_addr;
      mem_en_d = 1'b0;
      clr_acc  = 1'b0;
      vld_d    = (vld_q << 1) | RD_LAT'(mem_en);

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               clr_acc = 1'b1;
               addr_d  = base_addr;
               rem_d   = length;
               if (length != '0) begin
                  state_d  = ISSUE;
                  mem_en_d = 1'b1;
               end else begin
                  state_d = FIN;
               end
            end
         end
         ISSUE: begin
            if (abort) begin
               state_d = IDLE;
               vld_d   = '0;
            end else if (rem_q == 1) begin
               // The last read is still in flight after this cycle, so the
               // pipeline is never empty here and DRAIN is always next.
               rem_d   = '0;
               state_d = DRAIN;
            end else begin
               rem_d    = rem_q - 1'b1;
               addr_d   = mem_addr + 1'b1;   // wraps modulo 2**ADDR_W
               mem_en_d = 1'b1;
            end
         end
         DRAIN: begin
            if (abort) begin
               state_d = IDLE;
               vld_d   = '0;
            end else if (vld_rest == '0) begin
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == ISSUE) || (state_d == DRAIN);
      done_d = (state_d == FIN);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         mem_en   <= 1'b0;
         mem_addr <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         vld_q    <= '0;
         sum      <= '0;
         overflow <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         mem_en   <= mem_en_d;
         mem_addr <= addr_d;
         busy     <= busy_d;
         done     <= done_d;
         vld_q    <= vld_d;
         if (clr_acc) begin
            sum      <= '0;
            overflow <= 1'b0;
         end else if (acc_en) begin
            sum      <= acc_full[SUM_W-1:0];
            overflow <= overflow | acc_full[SUM_W];
         end
      end
   end

endmodule
